// File: rtl/adc_serial_multilane.sv
// Controller for a multi-lane serial-output SAR ADC. It resets the converter,
// triggers conversions, waits out the busy phase with a timeout, clocks the
// serial lanes in and presents the result one channel per clock.
module adc_serial_multilane #(
   parameter int W_DATA     = 18,
   parameter int N_CHAN     = 8,
   parameter int N_LANE     = 2,
   parameter int T_RESET    = 4,
   parameter int T_BUSY_MAX = 1023
) (
   input  logic                      clk_in,
   input  logic                      n_rst_in,
   input  logic                      cstart_in,
   input  logic                      cstop_in,
   input  logic                      single_in,
   input  logic [2:0]                os_in,
   input  logic                      update_in,
   input  logic [15:0]               delay_in,
   input  logic                      adc_busy_in,
   input  logic [N_LANE-1:0]         adc_data_in,
   output logic [2:0]                adc_os_out,
   output logic                      adc_convst_out,
   output logic                      adc_reset_out,
   output logic                      adc_sclk_out,
   output logic                      adc_n_cs_out,
   output logic [W_DATA-1:0]         data_out,
   output logic [$clog2(N_CHAN)-1:0] chan_out,
   output logic                      data_valid_out,
   output logic                      timeout_out
);

   localparam int B     = W_DATA * N_CHAN / N_LANE;  // bits per lane per frame
   localparam int CPL   = N_CHAN / N_LANE;           // channels per lane
   localparam int CH_W  = $clog2(N_CHAN);
   localparam int W_RD  = $clog2(2 * B + 1);
   localparam int W_TO  = $clog2(T_BUSY_MAX + 1);
   localparam int W_MX  = (W_RD > W_TO) ? W_RD : W_TO;
   localparam int CNT_W = (W_MX > 16) ? W_MX : 16;   // also covers the 16-bit delay

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_CONV, S_WAIT_HI, S_WAIT_LO, S_READ, S_EMIT, S_DELAY
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               run_q, run_d;
   logic [2:0]         os_q, os_d;
   logic [15:0]        delay_q, delay_d;
   logic [B-1:0]       sh_q [N_LANE];
   logic [B-1:0]       sh_d [N_LANE];
   logic               convst_q, convst_d;
   logic               rst_out_q, rst_out_d;
   logic               sclk_q, sclk_d;
   logic               n_cs_q, n_cs_d;
   logic [W_DATA-1:0]  data_q, data_d;
   logic [CH_W-1:0]    chan_q, chan_d;
   logic               valid_q, valid_d;
   logic               timeout_q, timeout_d;
   logic               expired;
   logic [W_DATA-1:0]  word [N_CHAN];

   // Lane l holds its channels back to back, first channel in the top bits.
   for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_word
      assign word[gi] = sh_q[gi / CPL][B - 1 - (gi % CPL) * W_DATA -: W_DATA];
   end

   assign expired = (cnt_q >= CNT_W'(T_BUSY_MAX - 1));

   // Next-state, counters, capture shift and the registered output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      os_d      = os_q;
      delay_d   = delay_q;
      sh_d      = sh_q;
      timeout_d = 1'b0;

      // Stop outranks start; a start anywhere at least arms continuous mode.
      if (cstop_in)       run_d = 1'b0;
      else if (cstart_in) run_d = 1'b1;

      case (state_q)
         S_RST: begin
            if (cnt_q == CNT_W'(T_RESET - 1)) state_d = S_IDLE;
            else                              cnt_d   = cnt_q + 1'b1;
         end
         S_IDLE: begin
            if (!cstop_in && (cstart_in || single_in)) begin
               state_d = S_CONV;
               cnt_d   = '0;
               if (!cstart_in) run_d = 1'b0;
            end
         end
         S_CONV: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_WAIT_HI;
               cnt_d   = '0;
            end
         end
         S_WAIT_HI: begin
            cnt_d = cnt_q + 1'b1;
            if (expired) begin
               state_d   = S_RST;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else if (adc_busy_in) begin
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            cnt_d = cnt_q + 1'b1;
            if (!adc_busy_in) begin
               state_d = S_READ;
               cnt_d   = '0;
            end else if (expired) begin
               state_d   = S_RST;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end
         end
         S_READ: begin
            // Even count = sclk low phase; its closing edge raises sclk and samples.
            if (!cnt_q[0]) begin
               for (int l = 0; l < N_LANE; l++) sh_d[l] = {sh_q[l][B-2:0], adc_data_in[l]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(2 * B - 1)) begin
               state_d = S_EMIT;
               cnt_d   = '0;
            end
         end
         S_EMIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N_CHAN - 1)) begin
               cnt_d = '0;
               if (!run_d)              state_d = S_IDLE;
               else if (delay_q == '0)  state_d = S_CONV;
               else                     state_d = S_DELAY;
            end
         end
         S_DELAY: begin
            cnt_d = cnt_q + 1'b1;
            if (!run_d) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_W'(delay_q) - CNT_W'(1)) begin
               state_d = S_CONV;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_RST;
            cnt_d   = '0;
         end
      endcase

      // A settings update aborts whatever is in flight.
      if (update_in) begin
         state_d   = S_RST;
         cnt_d     = '0;
         run_d     = 1'b0;
         os_d      = os_in;
         delay_d   = delay_in;
         timeout_d = 1'b0;
      end

      // Outputs are decoded from the next state so they line up with it.
      convst_d  = (state_d == S_CONV);
      rst_out_d = (state_d == S_RST);
      n_cs_d    = (state_d != S_READ);
      sclk_d    = (state_d == S_READ) ? cnt_d[0] : 1'b1;
      valid_d   = (state_d == S_EMIT);
      data_d    = data_q;
      chan_d    = chan_q;
      if (state_d == S_EMIT) begin
         chan_d = cnt_d[CH_W-1:0];
         data_d = word[cnt_d[CH_W-1:0]];
      end
   end

   // All state and outputs; reset forces the ADC into reset with the bus idle.
   always_ff @(posedge clk_in or negedge n_rst_in) begin
      if (!n_rst_in) begin
         state_q   <= S_RST;
         cnt_q     <= '0;
         run_q     <= 1'b0;
         os_q      <= '0;
         delay_q   <= '0;
         for (int l = 0; l < N_LANE; l++) sh_q[l] <= '0;
         convst_q  <= 1'b0;
         rst_out_q <= 1'b1;
         sclk_q    <= 1'b1;
         n_cs_q    <= 1'b1;
         data_q    <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         os_q      <= os_d;
         delay_q   <= delay_d;
         sh_q      <= sh_d;
         convst_q  <= convst_d;
         rst_out_q <= rst_out_d;
         sclk_q    <= sclk_d;
         n_cs_q    <= n_cs_d;
         data_q    <= data_d;
         chan_q    <= chan_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign adc_os_out     = os_q;
   assign adc_convst_out = convst_q;
   assign adc_reset_out  = rst_out_q;
   assign adc_sclk_out   = sclk_q;
   assign adc_n_cs_out   = n_cs_q;
   assign data_out       = data_q;
   assign chan_out       = chan_q;
   assign data_valid_out = valid_q;
   assign timeout_out    = timeout_q;

endmodule

// File: tb/tb_adc_serial_multilane.sv
// Bench for adc_serial_multilane: behavioural ADC models feed two instances
// (default 8ch/2-lane and 6ch/1-lane); frames are scoreboarded per channel.
module tb_adc_serial_multilane;

   localparam int W      = 18;
   localparam int NC     = 8;
   localparam int NL     = 2;
   localparam int TR     = 4;
   localparam int TB_MAX = 1023;
   localparam int B      = W * NC / NL;
   localparam int CPL    = NC / NL;
   localparam int NC6    = 6;
   localparam int B6     = W * NC6;

   typedef struct { int chan; logic [W-1:0] data; } word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          n_rst = 1'b0;
   logic          cstart = 1'b0, cstop = 1'b0, single = 1'b0, update = 1'b0, busy = 1'b0;
   logic [2:0]    os = '0;
   logic [15:0]   delay = '0;
   logic [NL-1:0] adc_data = '0;
   logic [2:0]    os_out;
   logic          convst, reset_out, sclk, n_cs, valid, timeout;
   logic [W-1:0]  dout;
   logic [2:0]    chan;

   logic          single6 = 1'b0, busy6 = 1'b0;
   logic [0:0]    adc_data6 = '0;
   logic [2:0]    os_out6;
   logic          convst6, reset_out6, sclk6, n_cs6, valid6, timeout6;
   logic [W-1:0]  dout6;
   logic [2:0]    chan6;

   adc_serial_multilane #(.W_DATA(W), .N_CHAN(NC), .N_LANE(NL), .T_RESET(TR), .T_BUSY_MAX(TB_MAX)) u_dut (
      .clk_in(clk), .n_rst_in(n_rst), .cstart_in(cstart), .cstop_in(cstop), .single_in(single),
      .os_in(os), .update_in(update), .delay_in(delay), .adc_busy_in(busy), .adc_data_in(adc_data),
      .adc_os_out(os_out), .adc_convst_out(convst), .adc_reset_out(reset_out), .adc_sclk_out(sclk),
      .adc_n_cs_out(n_cs), .data_out(dout), .chan_out(chan), .data_valid_out(valid), .timeout_out(timeout));

   adc_serial_multilane #(.W_DATA(W), .N_CHAN(NC6), .N_LANE(1), .T_RESET(TR), .T_BUSY_MAX(TB_MAX)) u_dut6 (
      .clk_in(clk), .n_rst_in(n_rst), .cstart_in(1'b0), .cstop_in(1'b0), .single_in(single6),
      .os_in(3'd0), .update_in(1'b0), .delay_in(16'd0), .adc_busy_in(busy6), .adc_data_in(adc_data6),
      .adc_os_out(os_out6), .adc_convst_out(convst6), .adc_reset_out(reset_out6), .adc_sclk_out(sclk6),
      .adc_n_cs_out(n_cs6), .data_out(dout6), .chan_out(chan6), .data_valid_out(valid6), .timeout_out(timeout6));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- ADC model, default instance ----------------
   logic [W-1:0] frame [NC];
   word_t        exp_q[$];
   bit           fixed_mode = 1'b1;
   bit           no_busy = 1'b0;
   bit           abort_pending = 1'b0;
   int           aborts = 0;
   int           busy_wait = 0, busy_len = 0, rises = 0, ncs_low = 0;
   logic         m_prev_convst = 1'b0, m_prev_ncs = 1'b1, m_prev_sclk = 1'b1;

   function automatic logic lane_bit(input int l, input int i);
      int ch, b;
      if (i >= B) return 1'b0;
      ch = l * CPL + i / W;
      b  = W - 1 - i % W;
      return frame[ch][b];
   endfunction

   always @(negedge clk) begin
      if (convst && !m_prev_convst) begin
         for (int k = 0; k < NC; k++) frame[k] = fixed_mode ? W'(1111 * (k + 1)) : W'($urandom);
         busy_wait = no_busy ? 0 : $urandom_range(1, 3);
         busy_len  = $urandom_range(5, 30);
      end else if (busy_wait > 0) begin
         busy_wait--;
         if (busy_wait == 0) busy = 1'b1;
      end else if (busy) begin
         busy_len--;
         if (busy_len <= 0) busy = 1'b0;
      end
      if (!n_cs) begin
         if (sclk && !m_prev_sclk) rises++;
         ncs_low++;
         if (!sclk) for (int l = 0; l < NL; l++) adc_data[l] = lane_bit(l, rises);
      end else begin
         if (!m_prev_ncs) begin
            if (abort_pending) begin
               abort_pending = 1'b0;
               aborts++;
            end else begin
               check("sclk_pulses", rises, B);
               check("read_clocks", ncs_low, 2 * B);
               check("sclk_idle_high", sclk, 1);
               for (int k = 0; k < NC; k++) exp_q.push_back('{chan: k, data: frame[k]});
            end
         end
         rises   = 0;
         ncs_low = 0;
      end
      m_prev_convst = convst;
      m_prev_ncs    = n_cs;
      m_prev_sclk   = sclk;
   end

   // ---------------- monitor, default instance ----------------
   int    frames_done = 0, run_len = 0, conv_len = 0, timeouts = 0;
   logic  mon_prev_valid = 1'b0, mon_prev_convst = 1'b0;
   word_t last_w = '{chan: 0, data: '0};

   always @(negedge clk) begin
      if (valid) begin
         check("word_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            last_w = exp_q.pop_front();
            check("word_chan", chan, last_w.chan);
            check("word_data", dout, last_w.data);
         end
         run_len++;
      end else if (mon_prev_valid) begin
         check("valid_run_len", run_len, NC);
         check("hold_data", dout, last_w.data);
         check("hold_chan", chan, last_w.chan);
         frames_done++;
         run_len = 0;
      end
      if (convst) conv_len++;
      else if (mon_prev_convst) begin
         check("convst_len", conv_len, 2);
         conv_len = 0;
      end
      if (timeout) timeouts++;
      mon_prev_valid  = valid;
      mon_prev_convst = convst;
   end

   // ---------------- ADC model + monitor, 6ch single-lane instance ----------------
   logic [W-1:0] frame6 [NC6];
   word_t        exp6_q[$];
   int           b6_cnt = 0, rises6 = 0, ncs_low6 = 0, frames6 = 0;
   logic         p6_convst = 1'b0, p6_ncs = 1'b1, p6_sclk = 1'b1, p6_valid = 1'b0;
   word_t        w6;

   always @(negedge clk) begin
      if (convst6 && !p6_convst) begin
         for (int k = 0; k < NC6; k++) frame6[k] = W'($urandom);
         b6_cnt = 8;
      end else if (b6_cnt > 0) begin
         b6_cnt--;
      end
      busy6 = (b6_cnt > 0 && b6_cnt <= 6);
      if (!n_cs6) begin
         if (sclk6 && !p6_sclk) rises6++;
         ncs_low6++;
         if (!sclk6 && rises6 < B6) adc_data6[0] = frame6[rises6 / W][W - 1 - rises6 % W];
      end else begin
         if (!p6_ncs) begin
            check("sclk_pulses_6", rises6, B6);
            check("read_clocks_6", ncs_low6, 2 * B6);
            for (int k = 0; k < NC6; k++) exp6_q.push_back('{chan: k, data: frame6[k]});
         end
         rises6   = 0;
         ncs_low6 = 0;
      end
      if (valid6) begin
         check("word6_expected", exp6_q.size() > 0, 1);
         if (exp6_q.size() > 0) begin
            w6 = exp6_q.pop_front();
            check("word6_chan", chan6, w6.chan);
            check("word6_data", dout6, w6.data);
         end
      end else if (p6_valid) begin
         frames6++;
      end
      p6_convst = convst6;
      p6_ncs    = n_cs6;
      p6_sclk   = sclk6;
      p6_valid  = valid6;
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic sig(input int which);
      case (which)
         0: return valid;
         1: return convst;
         2: return n_cs;
         3: return timeout;
         4: return reset_out;
         default: return 1'b0;
      endcase
   endfunction

   task automatic pulse(input int which);
      @(negedge clk);
      case (which)
         0: single  = 1'b1;
         1: cstart  = 1'b1;
         2: cstop   = 1'b1;
         3: update  = 1'b1;
         4: single6 = 1'b1;
         default: ;
      endcase
      @(negedge clk);
      single = 1'b0; cstart = 1'b0; cstop = 1'b0; update = 1'b0; single6 = 1'b0;
   endtask

   task automatic wait_sig(input int which, input logic lvl, input int budget, input string name);
      int n = 0;
      while (sig(which) !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, sig(which) === lvl, 1);
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int n = 0;
      while (frames_done < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, frames_done, target);
   endtask

   task automatic count_convst(input int cycles, output int rises_seen);
      logic prev = convst;
      rises_seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (convst && !prev) rises_seen++;
         prev = convst;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int n, f0, g;
      repeat (3) @(negedge clk);
      check("rst_n_cs", n_cs, 1);
      check("rst_sclk", sclk, 1);
      check("rst_reset_out", reset_out, 1);
      check("rst_convst", convst, 0);
      check("rst_valid", valid, 0);
      check("rst_timeout", timeout, 0);
      check("rst_os", os_out, 0);
      check("rst_data", dout, 0);
      check("rst_chan", chan, 0);

      // start during the post-reset ADC reset must be ignored
      n_rst  = 1'b1;
      single = 1'b1;
      @(negedge clk);
      single = 1'b0;
      count_convst(20, n);
      check("start_in_reset_ignored", n, 0);

      // 6-channel single-lane build: 108 sclk periods over 216 READ clocks
      pulse(4);
      n = 0;
      while (frames6 < 1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("frames6", frames6, 1);

      // update: ADC reset pulse length and os latch
      os = 3'd5;
      pulse(3);
      n = 0;
      while (reset_out && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("reset_pulse_len", n, TR);
      check("os_latched", os_out, 5);

      // single conversion with chan k = 1111*(k+1), then back to idle
      fixed_mode = 1'b1;
      f0 = frames_done;
      pulse(0);
      wait_frames(f0 + 1, 2000, "single_frames");
      count_convst(50, n);
      check("single_then_idle", n, 0);

      // continuous with 10-clock delay; stop during the second READ
      fixed_mode = 1'b0;
      os = 3'd0;
      delay = 16'd10;
      pulse(3);
      wait_sig(4, 1'b0, 50, "upd_reset_done");
      f0 = frames_done;
      pulse(1);
      wait_sig(0, 1'b1, 2000, "cont_first_valid");
      wait_sig(0, 1'b0, 50, "cont_first_end");
      g = 0;
      while (!convst && g < 100) begin
         g++;
         @(negedge clk);
      end
      check("delay_gap", g, 10);
      wait_sig(2, 1'b0, 200, "cont_second_read");
      repeat (30) @(negedge clk);
      pulse(2);
      wait_frames(f0 + 2, 2000, "cont_frames");
      count_convst(100, n);
      check("stop_then_idle", n, 0);

      // busy never arrives: timeout after T_BUSY_MAX clocks, no data
      no_busy = 1'b1;
      f0 = frames_done;
      pulse(0);
      wait_sig(1, 1'b1, 20, "to_convst_hi");
      wait_sig(1, 1'b0, 20, "to_convst_lo");
      n = 0;
      while (!timeout && n < TB_MAX + 20) begin
         n++;
         @(negedge clk);
      end
      check("timeout_cycle", n, TB_MAX);
      check("timeout_reset_out", reset_out, 1);
      @(negedge clk);
      check("timeout_one_clk", timeout, 0);
      no_busy = 1'b0;
      wait_sig(4, 1'b0, 50, "to_reset_done");
      check("timeout_no_frame", frames_done, f0);
      check("timeout_count", timeouts, 1);

      // update with os=3 during READ aborts the frame
      f0 = frames_done;
      pulse(0);
      wait_sig(2, 1'b0, 200, "upd_read");
      repeat (20) @(negedge clk);
      abort_pending = 1'b1;
      os = 3'd3;
      pulse(3);
      check("upd_os_out", os_out, 3);
      check("upd_reset_out", reset_out, 1);
      check("upd_n_cs", n_cs, 1);
      wait_sig(4, 1'b0, 50, "upd2_reset_done");
      repeat (50) @(negedge clk);
      check("upd_no_frame", frames_done, f0);
      check("upd_aborts", aborts, 1);

      // asynchronous reset during READ
      f0 = frames_done;
      pulse(0);
      wait_sig(2, 1'b0, 200, "arst_read");
      repeat (15) @(negedge clk);
      abort_pending = 1'b1;
      #2;
      n_rst = 1'b0;
      #1;
      check("arst_n_cs_async", n_cs, 1);
      check("arst_sclk_async", sclk, 1);
      check("arst_reset_out_async", reset_out, 1);
      check("arst_valid_async", valid, 0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      wait_sig(4, 1'b0, 50, "arst_reset_done");
      check("arst_os_cleared", os_out, 0);
      repeat (100) @(negedge clk);
      check("arst_no_frame", frames_done, f0);
      check("arst_aborts", aborts, 2);

      // random singles
      for (int i = 0; i < 4; i++) begin
         f0 = frames_done;
         pulse(0);
         wait_frames(f0 + 1, 2000, "rand_single_frames");
      end

      // continuous with zero delay; stop after two frames lets the third finish
      f0 = frames_done;
      pulse(1);
      wait_frames(f0 + 2, 4000, "cont0_two_frames");
      pulse(2);
      wait_frames(f0 + 3, 2000, "cont0_three_frames");
      count_convst(100, n);
      check("cont0_then_idle", n, 0);

      check("queue_drained", exp_q.size(), 0);
      check("queue6_drained", exp6_q.size(), 0);
      check("timeouts_total", timeouts, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
